// File: rtl/tour_cmd_sched.sv
// Command-source scheduler in front of cmd_proc: passes UART commands through while idle,
// and on tour_go walks the knight's-tour move list as vertical then horizontal segments.
module tour_cmd_sched #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  input  logic             tour_go,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp
);

  localparam logic [3:0]       OP_MOVE    = 4'h2;
  localparam logic [3:0]       OP_FANFARE = 4'h3;
  localparam logic [7:0]       HEAD_N     = 8'h00;
  localparam logic [7:0]       HEAD_W     = 8'h3F;
  localparam logic [7:0]       HEAD_S     = 8'h7F;
  localparam logic [7:0]       HEAD_E     = 8'hBF;
  localparam logic [7:0]       RESP_DONE  = 8'hA5;
  localparam logic [7:0]       RESP_BUSY  = 8'h5A;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_MOVES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    HOLD_V = 3'd2,
    HORZ   = 3'd3,
    HOLD_H = 3'd4
  } state_t;

  // Knight step as sign/magnitude per axis; a zero magnitude means "no motion".
  typedef struct packed {
    logic       x_neg;
    logic [1:0] x_mag;
    logic       y_neg;
    logic [1:0] y_mag;
  } step_t;

  state_t           state_r;
  logic [IDX_W-1:0] mv_indx_r;
  step_t            step_s;
  logic [15:0]      vert_cmd_s;
  logic [15:0]      horz_cmd_s;
  logic             last_move_s;

  // Lowest set bit of the one-hot move wins; an empty move decodes to no motion.
  function automatic step_t decode_move(input logic [7:0] mv);
    step_t st;
    casez (mv)
      8'b???????1: st = {1'b1, 2'd1, 1'b0, 2'd2};
      8'b??????10: st = {1'b0, 2'd1, 1'b0, 2'd2};
      8'b?????100: st = {1'b1, 2'd2, 1'b0, 2'd1};
      8'b????1000: st = {1'b1, 2'd2, 1'b1, 2'd1};
      8'b???10000: st = {1'b1, 2'd1, 1'b1, 2'd2};
      8'b??100000: st = {1'b0, 2'd1, 1'b1, 2'd2};
      8'b?1000000: st = {1'b0, 2'd2, 1'b1, 2'd1};
      8'b10000000: st = {1'b0, 2'd2, 1'b0, 2'd1};
      default:     st = {1'b0, 2'd0, 1'b0, 2'd0};
    endcase
    return st;
  endfunction

  function automatic logic [15:0] vert_segment(input step_t st);
    logic [7:0] heading;
    if (st.y_neg) begin
      heading = HEAD_S;
    end else begin
      heading = HEAD_N;
    end
    return {OP_MOVE, heading, 2'b00, st.y_mag};
  endfunction

  // No horizontal motion (empty move) is still issued, pointing north.
  function automatic logic [15:0] horz_segment(input step_t st);
    logic [7:0] heading;
    if (st.x_mag == 2'd0) begin
      heading = HEAD_N;
    end else if (st.x_neg) begin
      heading = HEAD_W;
    end else begin
      heading = HEAD_E;
    end
    return {OP_FANFARE, heading, 2'b00, st.x_mag};
  endfunction

  assign step_s      = decode_move(move);
  assign vert_cmd_s  = vert_segment(step_s);
  assign horz_cmd_s  = horz_segment(step_s);
  assign last_move_s = (mv_indx_r == LAST_IDX);
  assign mv_indx     = mv_indx_r;

  // Tour sequencer: each segment waits for consume, then for cmd_proc to finish it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      mv_indx_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tour_go) begin
            mv_indx_r <= '0;
            state_r   <= VERT;
          end
        end
        VERT: begin
          if (clr_cmd_rdy) begin
            state_r <= HOLD_V;
          end
        end
        HOLD_V: begin
          if (send_resp) begin
            state_r <= HORZ;
          end
        end
        HORZ: begin
          if (clr_cmd_rdy) begin
            state_r <= HOLD_H;
          end
        end
        HOLD_H: begin
          if (send_resp) begin
            if (last_move_s) begin
              state_r <= IDLE;
            end else begin
              mv_indx_r <= mv_indx_r + IDX_ONE;
              state_r   <= VERT;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          mv_indx_r <= '0;
        end
      endcase
    end
  end

  // Command-port mux: UART passthrough when idle, segment commands during a tour.
  always_comb begin
    cmd              = 16'h0000;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_DONE;
    case (state_r)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
      end
      VERT: begin
        cmd     = vert_cmd_s;
        cmd_rdy = 1'b1;
        resp    = RESP_BUSY;
      end
      HOLD_V: begin
        cmd  = vert_cmd_s;
        resp = RESP_BUSY;
      end
      HORZ: begin
        cmd     = horz_cmd_s;
        cmd_rdy = 1'b1;
        resp    = RESP_BUSY;
      end
      HOLD_H: begin
        cmd = horz_cmd_s;
        if (last_move_s) begin
          resp = RESP_DONE;
        end else begin
          resp = RESP_BUSY;
        end
      end
      default: begin
        cmd  = 16'h0000;
        resp = RESP_DONE;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Directed bench for tour_cmd_sched: a vector table for the single-step behaviour,
// then a full tour against a small cmd_proc model, UART hold-off and mid-tour reset.
module tb_tour_cmd_sched;
  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      cmd_UART = 16'h0000;
  logic             cmd_rdy_UART = 1'b0;
  logic             clr_cmd_rdy_UART;
  logic             tour_go = 1'b0;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy = 1'b0;
  logic             send_resp = 1'b0;
  logic [7:0]       resp;

  logic [7:0] move_drv = 8'h00;
  logic       use_store = 1'b0;
  logic [7:0] tour_mv [32];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign move = use_store ? tour_mv[mv_indx] : move_drv;

  tour_cmd_sched #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .tour_go(tour_go), .move(move),
    .mv_indx(mv_indx), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp)
  );

  typedef struct {
    logic [15:0] c_uart;
    logic        r_uart;
    logic        clr;
    logic        go;
    logic [7:0]  mv;
    logic        sresp;
    logic        chk_cmd;
    logic [15:0] e_cmd;
    logic        e_rdy;
    logic        e_clru;
    logic [7:0]  e_resp;
    logic [4:0]  e_idx;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] c_uart, input logic r_uart, input logic clr,
                              input logic go, input logic [7:0] mv, input logic sresp,
                              input logic chk_cmd, input logic [15:0] e_cmd, input logic e_rdy,
                              input logic e_clru, input logic [7:0] e_resp, input logic [4:0] e_idx);
    vec_t v;
    v.c_uart = c_uart; v.r_uart = r_uart; v.clr = clr; v.go = go; v.mv = mv; v.sresp = sresp;
    v.chk_cmd = chk_cmd; v.e_cmd = e_cmd; v.e_rdy = e_rdy; v.e_clru = e_clru;
    v.e_resp = e_resp; v.e_idx = e_idx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: signed (dx,dy) per move bit, converted to a segment command.
  function automatic logic [15:0] ref_seg(input logic [7:0] mv, input bit horiz);
    int dx = 0;
    int dy = 0;
    bit found = 1'b0;
    int mag;
    logic [7:0] hd;
    for (int b = 0; b < 8; b++) begin
      if (!found && mv[b]) begin
        found = 1'b1;
        case (b)
          0: begin dx = -1; dy =  2; end
          1: begin dx =  1; dy =  2; end
          2: begin dx = -2; dy =  1; end
          3: begin dx = -2; dy = -1; end
          4: begin dx = -1; dy = -2; end
          5: begin dx =  1; dy = -2; end
          6: begin dx =  2; dy = -1; end
          default: begin dx = 2; dy = 1; end
        endcase
      end
    end
    if (!horiz) begin
      hd  = (dy < 0) ? 8'h7F : 8'h00;
      mag = (dy < 0) ? -dy : dy;
      return {4'h2, hd, 4'(mag)};
    end
    hd  = (dx > 0) ? 8'hBF : ((dx < 0) ? 8'h3F : 8'h00);
    mag = (dx < 0) ? -dx : dx;
    return {4'h3, hd, 4'(mag)};
  endfunction

  // Model cmd_proc for one segment: wait for cmd_rdy, check, consume, then finish it.
  task automatic do_seg(input string tag, input logic [15:0] e_cmd, input logic [4:0] e_idx,
                        input logic [7:0] e_resp, input bit finish);
    int n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!cmd_rdy && n < 20);
    chk({tag, "_rdy"}, {15'd0, cmd_rdy}, 16'h0001);
    chk({tag, "_cmd"}, cmd, e_cmd);
    chk({tag, "_idx"}, {11'd0, mv_indx}, {11'd0, e_idx});
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #2;
    chk({tag, "_held"}, {15'd0, cmd_rdy}, 16'h0000);
    if (finish) begin
      @(negedge clk);
      send_resp = 1'b1;
      #2;
      chk({tag, "_resp"}, {8'd0, resp}, {8'd0, e_resp});
      @(negedge clk);
      send_resp = 1'b0;
    end
  endtask

  logic tour_mon   = 1'b0;
  logic uart_leak  = 1'b0;
  logic prev_rdy   = 1'b0;
  int   seg_cnt    = 0;

  // Tour monitor: counts issued segments and catches any UART consume strobe.
  always @(negedge clk) begin
    #4;
    if (tour_mon) begin
      if (clr_cmd_rdy_UART) uart_leak <= 1'b1;
      if (cmd_rdy && !prev_rdy) seg_cnt <= seg_cnt + 1;
    end
    prev_rdy <= cmd_rdy;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  localparam logic [8*24-1:0] TOUR = {
    8'h02, 8'h08, 8'h01, 8'h04, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h0C, 8'h30, 8'hC0, 8'h03, 8'h01, 8'h02, 8'h04, 8'h08,
    8'h10, 8'h20, 8'h40, 8'h80, 8'h81, 8'h00, 8'h06, 8'h18};

  vec_t vt [23];

  initial begin
    for (int i = 0; i < 32; i++) tour_mv[i] = (i < 24) ? TOUR[8*i +: 8] : 8'h00;

    //              c_uart  ru clr go  mv    sr chk e_cmd   rdy clu resp   idx
    vt[0]  = mk(16'h0000, 0, 0, 0, 8'h02, 0, 1, 16'h0000, 0, 0, 8'hA5, 5'd0);
    vt[1]  = mk(16'h3001, 1, 0, 0, 8'h02, 0, 1, 16'h3001, 1, 0, 8'hA5, 5'd0);
    vt[2]  = mk(16'h3001, 1, 1, 0, 8'h02, 0, 1, 16'h3001, 1, 1, 8'hA5, 5'd0);
    vt[3]  = mk(16'h3001, 0, 0, 1, 8'h02, 0, 1, 16'h3001, 0, 0, 8'hA5, 5'd0);
    vt[4]  = mk(16'h3001, 0, 0, 0, 8'h02, 0, 1, 16'h2002, 1, 0, 8'h5A, 5'd0);
    vt[5]  = mk(16'h3001, 0, 1, 0, 8'h02, 0, 1, 16'h2002, 1, 0, 8'h5A, 5'd0);
    vt[6]  = mk(16'h0000, 0, 0, 0, 8'h02, 0, 0, 16'h0000, 0, 0, 8'h5A, 5'd0);
    vt[7]  = mk(16'h0000, 0, 0, 0, 8'h02, 1, 0, 16'h0000, 0, 0, 8'h5A, 5'd0);
    vt[8]  = mk(16'h0000, 0, 0, 0, 8'h02, 0, 1, 16'h3BF1, 1, 0, 8'h5A, 5'd0);
    vt[9]  = mk(16'h0000, 0, 1, 0, 8'h02, 1, 1, 16'h3BF1, 1, 0, 8'h5A, 5'd0);
    vt[10] = mk(16'h0000, 0, 0, 0, 8'h02, 0, 0, 16'h0000, 0, 0, 8'h5A, 5'd0);
    vt[11] = mk(16'h0000, 0, 0, 0, 8'h02, 1, 0, 16'h0000, 0, 0, 8'h5A, 5'd0);
    vt[12] = mk(16'h0000, 0, 0, 0, 8'h08, 0, 1, 16'h27F1, 1, 0, 8'h5A, 5'd1);
    vt[13] = mk(16'h0000, 0, 0, 0, 8'h08, 1, 1, 16'h27F1, 1, 0, 8'h5A, 5'd1);
    vt[14] = mk(16'h0000, 0, 1, 0, 8'h08, 0, 1, 16'h27F1, 1, 0, 8'h5A, 5'd1);
    vt[15] = mk(16'h0000, 0, 1, 1, 8'h08, 0, 0, 16'h0000, 0, 0, 8'h5A, 5'd1);
    vt[16] = mk(16'h0000, 0, 0, 0, 8'h08, 0, 0, 16'h0000, 0, 0, 8'h5A, 5'd1);
    vt[17] = mk(16'h0000, 0, 0, 0, 8'h08, 1, 0, 16'h0000, 0, 0, 8'h5A, 5'd1);
    vt[18] = mk(16'h1234, 1, 1, 0, 8'h08, 0, 1, 16'h33F2, 1, 0, 8'h5A, 5'd1);
    vt[19] = mk(16'h0000, 0, 0, 0, 8'h08, 1, 0, 16'h0000, 0, 0, 8'h5A, 5'd1);
    vt[20] = mk(16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h2000, 1, 0, 8'h5A, 5'd2);
    vt[21] = mk(16'h0000, 0, 0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 8'h5A, 5'd2);
    vt[22] = mk(16'h0000, 0, 1, 0, 8'h00, 0, 1, 16'h3000, 1, 0, 8'h5A, 5'd2);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      cmd_UART     = vt[i].c_uart;
      cmd_rdy_UART = vt[i].r_uart;
      clr_cmd_rdy  = vt[i].clr;
      tour_go      = vt[i].go;
      move_drv     = vt[i].mv;
      send_resp    = vt[i].sresp;
      #2;
      if (vt[i].chk_cmd) chk($sformatf("v%0d_cmd", i), cmd, vt[i].e_cmd);
      chk($sformatf("v%0d_rdy", i), {15'd0, cmd_rdy}, {15'd0, vt[i].e_rdy});
      chk($sformatf("v%0d_clru", i), {15'd0, clr_cmd_rdy_UART}, {15'd0, vt[i].e_clru});
      chk($sformatf("v%0d_resp", i), {8'd0, resp}, {8'd0, vt[i].e_resp});
      chk($sformatf("v%0d_idx", i), {11'd0, mv_indx}, {11'd0, vt[i].e_idx});
    end

    // Full tour with UART traffic raised part-way through.
    @(negedge clk);
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; tour_go = 1'b0; cmd_rdy_UART = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    use_store = 1'b1;
    @(negedge clk);
    tour_mon = 1'b1;
    tour_go  = 1'b1;
    @(negedge clk);
    tour_go = 1'b0;
    for (int k = 0; k < NUM_MOVES; k++) begin
      if (k == 5) begin
        cmd_UART     = 16'h3001;
        cmd_rdy_UART = 1'b1;
      end
      do_seg($sformatf("t%0d_v", k), ref_seg(tour_mv[k], 1'b0), 5'(k), 8'h5A, 1'b1);
      do_seg($sformatf("t%0d_h", k), ref_seg(tour_mv[k], 1'b1), 5'(k),
             (k == NUM_MOVES - 1) ? 8'hA5 : 8'h5A, 1'b1);
    end
    tour_mon = 1'b0;
    #2;
    chk("tour_seg_cnt", 16'(seg_cnt), 16'd48);
    chk("tour_uart_leak", {15'd0, uart_leak}, 16'h0000);
    chk("post_cmd", cmd, 16'h3001);
    chk("post_rdy", {15'd0, cmd_rdy}, 16'h0001);
    chk("post_resp", {8'd0, resp}, 16'h00A5);
    chk("post_idx", {11'd0, mv_indx}, 16'd23);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("post_clru", {15'd0, clr_cmd_rdy_UART}, 16'h0001);
    @(negedge clk);
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;

    // Reset while in HOLD_V at mv_indx 7, then restart.
    @(negedge clk);
    tour_go = 1'b1;
    @(negedge clk);
    tour_go = 1'b0;
    for (int k = 0; k < 7; k++) begin
      do_seg($sformatf("r%0d_v", k), ref_seg(tour_mv[k], 1'b0), 5'(k), 8'h5A, 1'b1);
      do_seg($sformatf("r%0d_h", k), ref_seg(tour_mv[k], 1'b1), 5'(k), 8'h5A, 1'b1);
    end
    do_seg("r7_v", ref_seg(tour_mv[7], 1'b0), 5'd7, 8'h5A, 1'b0);
    cmd_UART = 16'h2345;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_rdy", {15'd0, cmd_rdy}, 16'h0000);
    chk("rst_idx", {11'd0, mv_indx}, 16'h0000);
    chk("rst_cmd", cmd, 16'h2345);
    chk("rst_resp", {8'd0, resp}, 16'h00A5);
    @(negedge clk);
    rst     = 1'b0;
    tour_go = 1'b1;
    #2;
    chk("restart_pre_rdy", {15'd0, cmd_rdy}, 16'h0000);
    @(negedge clk);
    tour_go = 1'b0;
    #2;
    chk("restart_rdy", {15'd0, cmd_rdy}, 16'h0001);
    chk("restart_idx", {11'd0, mv_indx}, 16'h0000);
    chk("restart_cmd", cmd, ref_seg(tour_mv[0], 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
